// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave peripheral: register map, status bits,
// FSM state encoding and the default frame width.
package spi_pkg;

  localparam int DATA_W = 8;

  localparam logic [3:0] ADDR_TX     = 4'd0;
  localparam logic [3:0] ADDR_CTRL   = 4'd2;
  localparam logic [3:0] ADDR_RX     = 4'd4;
  localparam logic [3:0] ADDR_STATUS = 4'd8;

  localparam int ST_NEW_DATA   = 0;
  localparam int ST_TX_PENDING = 1;
  localparam int ST_OVERRUN    = 2;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVR = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

endpackage

// File: rtl/spi_sync_edge.sv
// SYNC_STAGES-deep (>= 2) synchronizer for one SPI pin, with one-clk rise/fall
// pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise_p,
  output logic fall_p
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q      = sync_q[SYNC_STAGES-1];
  assign rise_p = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_p = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/peripheral_spi_slave.sv
// Memory-mapped SPI mode-0 slave for the J1 I/O bus; all SPI pins oversampled in clk.
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN: miso floats while ss is high or in reset.
module peripheral_spi_slave #(
  parameter int                 DATA_W      = spi_pkg::DATA_W,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  IDLE_TX     = '1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  input  logic        sck,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso
);
  import spi_pkg::*;

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(DATA_W - 1);

  logic sck_s, sck_rise_p, sck_fall_p;
  logic ss_s, ss_rise_p, ss_fall_p;
  logic mosi_s, mosi_rise_p, mosi_fall_p;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .d(sck), .q(sck_s), .rise_p(sck_rise_p), .fall_p(sck_fall_p)
  );

  // ss idles high, so its synchronizer resets high to avoid a false frame start
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .d(ss), .q(ss_s), .rise_p(ss_rise_p), .fall_p(ss_fall_p)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise_p(mosi_rise_p), .fall_p(mosi_fall_p)
  );

  logic unused_sigs;
  assign unused_sigs = ^{sck_s, ss_rise_p, mosi_rise_p, mosi_fall_p, d_in[15:DATA_W]};

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_pend_q, tx_pend_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              new_data_q, new_data_d;
  logic              overrun_q, overrun_d;
  logic              byte_done_q, byte_done_d;
  logic              miso_q, miso_d;
  logic [15:0]       d_out_q, d_out_d;

  logic        bus_rd, bus_wr;
  logic [15:0] status;

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_pend_d   = tx_pend_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    new_data_d  = new_data_q;
    overrun_d   = overrun_q;
    byte_done_d = byte_done_q;
    miso_d      = miso_q;
    d_out_d     = '0;

    bus_rd = cs & rd;
    bus_wr = cs & wr;

    status                = '0;
    status[ST_NEW_DATA]   = new_data_q;
    status[ST_TX_PENDING] = tx_pend_q;
    status[ST_OVERRUN]    = overrun_q;

    if (bus_rd) begin
      case (addr)
        ADDR_RX:     d_out_d = 16'(rx_data_q);
        ADDR_STATUS: d_out_d = status;
        default:     d_out_d = '0;
      endcase
    end

    // Clears are applied first so that same-cycle hardware sets win
    if (bus_rd && addr == ADDR_RX) begin
      new_data_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (bus_wr && addr == ADDR_CTRL) begin
      if (d_in[CTRL_FLUSH])   tx_pend_d = 1'b0;
      if (d_in[CTRL_CLR_OVR]) overrun_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        if (ss_fall_p) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (ss_s) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
          miso_d    = 1'b0;
        end else begin
          tx_sr_d     = tx_pend_q ? tx_data_q : IDLE_TX;
          tx_pend_d   = 1'b0;
          bit_cnt_d   = '0;
          byte_done_d = 1'b0;
          miso_d      = tx_sr_d[DATA_W-1];
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (ss_s) begin
          state_d     = S_IDLE;
          bit_cnt_d   = '0;
          byte_done_d = 1'b0;
          miso_d      = 1'b0;
        end else begin
          if (sck_rise_p) begin
            rx_sr_d   = {rx_sr_q[DATA_W-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              rx_data_d   = rx_sr_d;
              if (new_data_q) overrun_d = 1'b1;
              new_data_d  = 1'b1;
              byte_done_d = 1'b1;
            end
          end
          // The closing falling edge of a byte preloads the next one
          if (sck_fall_p) begin
            if (byte_done_q) begin
              tx_sr_d     = tx_pend_q ? tx_data_q : IDLE_TX;
              tx_pend_d   = 1'b0;
              byte_done_d = 1'b0;
              bit_cnt_d   = '0;
            end else begin
              tx_sr_d = tx_sr_q << 1;
            end
            miso_d = tx_sr_d[DATA_W-1];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A tx write lands after any load so the byte stays pending for the next frame
    if (bus_wr && addr == ADDR_TX) begin
      tx_data_d = d_in[DATA_W-1:0];
      tx_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tx_data_q   <= '0;
      tx_pend_q   <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      new_data_q  <= 1'b0;
      overrun_q   <= 1'b0;
      byte_done_q <= 1'b0;
      miso_q      <= 1'b0;
      d_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_pend_q   <= tx_pend_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      new_data_q  <= new_data_d;
      overrun_q   <= overrun_d;
      byte_done_q <= byte_done_d;
      miso_q      <= miso_d;
      d_out_q     <= d_out_d;
    end
  end

  assign d_out = d_out_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = (ss_s || !rst) ? 1'bz : miso_q;
`else
  assign miso = ss_s ? 1'b0 : miso_q;
`endif

endmodule

// File: tb/tb_peripheral_spi_slave.sv
// Directed bench for peripheral_spi_slave: a bus/SPI-master driver, a transaction-level
// model of the register file, and a per-cycle compare of d_out and idle miso.
`timescale 1ns/1ps
module tb_peripheral_spi_slave;

  localparam int HALF = 5;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] d_in = '0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] d_out;
  logic        sck = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic        miso;

  always #5 clk = ~clk;

  peripheral_spi_slave #(.DATA_W(8), .SYNC_STAGES(SYNC), .IDLE_TX(8'hFF)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0]  m_tx_data = '0, m_rx = '0, m_load = 8'hFF;
  logic        m_pend = 1'b0, m_new = 1'b0, m_ovr = 1'b0;
  logic [15:0] exp_dout = '0;
  int          ss_hi_cnt = 0;
  logic        chk_en = 1'b0;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  function automatic logic [15:0] model_read(input logic [3:0] a);
    case (a)
      4'd4:    return {8'h00, m_rx};
      4'd8:    return {13'b0, m_ovr, m_pend, m_new};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_dout  <= (rst && cs && rd) ? model_read(addr) : 16'h0000;
    ss_hi_cnt <= ss ? ss_hi_cnt + 1 : 0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk16("d_out_cycle", d_out, exp_dout);
      if (ss_hi_cnt > SYNC) chk1("miso_idle", miso, MISO_IDLE);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [15:0] v);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    if (a == 4'd0) begin
      m_tx_data = v[7:0];
      m_pend    = 1'b1;
    end else if (a == 4'd2) begin
      if (v[0]) m_pend = 1'b0;
      if (v[1]) m_ovr  = 1'b0;
    end
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] v;
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    v = d_out;
    cs = 1'b0; rd = 1'b0; addr = '0;
    if (a == 4'd4) begin
      m_new = 1'b0;
      m_ovr = 1'b0;
    end
    chk16(name, v, exp);
  endtask

  task automatic spi_begin();
    @(negedge clk);
    ss     = 1'b0;
    m_load = m_pend ? m_tx_data : 8'hFF;
    m_pend = 1'b0;
    wait_clk(2 * HALF);
  endtask

  task automatic spi_bit(input int idx, input logic b, output logic got);
    mosi = b;
    wait_clk(HALF);
    got = miso;
    chk1("miso_bit", got, m_load[7-idx]);
    sck = 1'b1;
    wait_clk(HALF);
    sck = 1'b0;
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    ss   = 1'b1;
    mosi = 1'b0;
    wait_clk(3 * SYNC + 4);
  endtask

  task automatic spi_frame(input logic [7:0] tx, input int nbits, output logic [7:0] got);
    logic b;
    got = '0;
    spi_begin();
    for (int i = 0; i < nbits; i++) begin
      spi_bit(i, tx[7-i], b);
      got[7-i] = b;
    end
    if (nbits == 8) begin
      if (m_new) m_ovr = 1'b1;
      m_rx   = tx;
      m_new  = 1'b1;
      m_load = m_pend ? m_tx_data : 8'hFF;
      m_pend = 1'b0;
    end
    spi_end();
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] part;
    logic       b;

    rst = 1'b0;
    wait_clk(3);
    chk16("reset_dout", d_out, 16'h0000);
    chk1("reset_miso", miso, MISO_IDLE);
    rst = 1'b1;
    wait_clk(4);
    chk_en = 1'b1;
    rd_chk("reset_status", 4'd8, 16'h0000);

    // Preloaded tx byte returned while 0xB9 is received
    bus_wr(4'd0, 16'h005A);
    rd_chk("t1_status_pending", 4'd8, 16'h0002);
    spi_frame(8'hB9, 8, got);
    chk16("t1_miso_byte", {8'h00, got}, 16'h005A);
    rd_chk("t1_status", 4'd8, 16'h0001);
    rd_chk("t1_rx", 4'd4, 16'h00B9);
    rd_chk("t1_status_after", 4'd8, 16'h0000);

    // Two frames without an rx read cause overrun
    spi_frame(8'h11, 8, got);
    spi_frame(8'h22, 8, got);
    rd_chk("t2_status", 4'd8, 16'h0005);
    rd_chk("t2_rx", 4'd4, 16'h0022);
    rd_chk("t2_status_after", 4'd8, 16'h0000);

    // Underflow returns the idle byte
    spi_frame(8'h3C, 8, got);
    chk16("t3_miso_byte", {8'h00, got}, 16'h00FF);
    rd_chk("t3_status", 4'd8, 16'h0001);
    rd_chk("t3_rx", 4'd4, 16'h003C);
    rd_chk("t3_status_after", 4'd8, 16'h0000);

    // Aborted partial frame followed by a full one
    spi_frame(8'hA5, 3, got);
    rd_chk("t4_status_abort", 4'd8, 16'h0000);
    spi_frame(8'hA5, 8, got);
    rd_chk("t4_rx", 4'd4, 16'h00A5);

    // Reset asserted after four bits of a frame
    bus_wr(4'd0, 16'h00C3);
    part = 8'hF0;
    spi_begin();
    for (int i = 0; i < 4; i++) spi_bit(i, part[7-i], b);
    @(negedge clk);
    rst = 1'b0;
    wait_clk(2);
    chk16("t5_rst_dout", d_out, 16'h0000);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    chk1("t5_rst_miso", miso, 1'bz);
`else
    chk1("t5_rst_miso", miso, 1'b0);
`endif
    ss = 1'b1; sck = 1'b0; mosi = 1'b0;
    m_tx_data = '0; m_rx = '0; m_pend = 1'b0; m_new = 1'b0; m_ovr = 1'b0;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(4);
    rd_chk("t5_status", 4'd8, 16'h0000);
    spi_frame(8'h81, 8, got);
    chk16("t5_miso_byte", {8'h00, got}, 16'h00FF);
    rd_chk("t5_rx", 4'd4, 16'h0081);

    // Flush, overrun clear, unmapped address
    bus_wr(4'd0, 16'h0077);
    rd_chk("t6_pending", 4'd8, 16'h0002);
    bus_wr(4'd2, 16'h0001);
    rd_chk("t6_flushed", 4'd8, 16'h0000);
    spi_frame(8'h12, 8, got);
    chk16("t6_miso_flushed", {8'h00, got}, 16'h00FF);
    spi_frame(8'h34, 8, got);
    rd_chk("t6_status_ovr", 4'd8, 16'h0005);
    bus_wr(4'd2, 16'h0002);
    rd_chk("t6_status_ovr_clr", 4'd8, 16'h0001);
    bus_wr(4'd6, 16'hFFFF);
    rd_chk("t6_unmapped", 4'd6, 16'h0000);
    rd_chk("t6_status_unchanged", 4'd8, 16'h0001);
    rd_chk("t6_rx", 4'd4, 16'h0034);

    // A second preloaded byte after underflow frames
    bus_wr(4'd0, 16'h00C6);
    spi_frame(8'h5E, 8, got);
    chk16("t7_miso_byte", {8'h00, got}, 16'h00C6);
    rd_chk("t7_rx", 4'd4, 16'h005E);

    wait_clk(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/peripheral_spi_slave.md
Name: peripheral_spi_slave

Overview:
- Memory-mapped SPI slave (target) peripheral on the J1 SoC I/O bus. It is the far-end counterpart of the SPI master peripheral.
- Receives bytes on mosi and returns CPU-supplied bytes on miso, both clocked by an external sck/ss.
- SPI mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first. All SPI pins are oversampled in the clk domain.
- Uses the same bus register style as the master: 16-bit data, 4-bit addr, cs/rd/wr strobes.

Parameters:
- DATA_W, 8: SPI frame width in bits; rx/tx data occupy d_in/d_out[DATA_W-1:0].
- SYNC_STAGES, 2: synchronizer depth for sck, ss and mosi; minimum 2.
- IDLE_TX, 8'hFF: byte shifted out when no tx data is pending (underflow).

Ports:
- clk, input, 1: system clock; sck must satisfy f_sck <= f_clk/8.
- rst, input, 1: asynchronous, active-low reset.
- d_in, input, 16: bus write data.
- cs, input, 1: peripheral select, active high.
- addr, input, 4: register address.
- rd, input, 1: read strobe.
- wr, input, 1: write strobe.
- d_out, output, 16: registered bus read data.
- sck, input, 1: SPI clock from the master.
- ss, input, 1: slave select, active low.
- mosi, input, 1: master-out data.
- miso, output, 1: slave-out data.

Behaviour:
- Reset (rst=0, asynchronous):
  - d_out=0, miso=0.
  - All registers and flags cleared; FSM goes to IDLE.
  - Reset asserted mid-frame discards the partial byte.
- Register map:
  - addr 0, write: tx_data <= d_in[7:0]; sets tx_pending.
  - addr 2, write: bit0=1 flushes tx (clears tx_pending); bit1=1 clears overrun.
  - addr 4, read: returns {8'h00, rx_data}; the same clk edge clears new_data and overrun.
  - addr 8, read: status {13'b0, overrun, tx_pending, new_data}.
  - Other addresses read 0 and ignore writes.
- Bus timing:
  - d_out is updated on the clk edge where cs&rd=1 (one-cycle latency) and forced to 0 in any cycle without cs&rd.
  - A write requires cs&wr for one cycle.
- Pin synchronization:
  - sck, ss and mosi each pass through SYNC_STAGES flops.
  - Edge detect on the synced sck: rise_p / fall_p, each a one-clk pulse.
  - ss falling edge: ss_fall_p.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: wait for ss_fall_p, then go to LOAD.
  - LOAD (1 clk):
    - Shift register tx_sr <= tx_pending ? tx_data : IDLE_TX; clears tx_pending; bit_cnt <= 0.
    - miso <= tx_sr MSB. Go to SHIFT.
  - SHIFT, on rise_p:
    - rx_sr <= {rx_sr[6:0], mosi_sync}; bit_cnt++.
    - At bit_cnt == 7:
      - rx_data <= completed byte.
      - If new_data is already 1, set overrun; rx_data is still overwritten.
      - Set new_data; set byte_done.
  - SHIFT, on fall_p:
    - If byte_done: reload tx_sr as in LOAD, clear byte_done, bit_cnt <= 0.
    - Otherwise: tx_sr <<= 1.
    - miso follows tx_sr[7].
  - SHIFT, synced ss high: return to IDLE, abort any partial frame, bit_cnt <= 0, no flag changes.
- Latency: from an sck pin edge to the miso change or new_data set is at most SYNC_STAGES+2 clk.
- miso is 0 whenever the synced ss is high.
- Simultaneous events:
  - An rx-data read in the same clk as byte completion leaves new_data=1; set has priority over clear.
  - A bus tx_data write during LOAD has no effect on the loaded byte; tx_pending stays 1 for the next frame.

Optional Feature:
- Macro: SPI_SLAVE_MISO_TRISTATE_EN.
  - Defined: miso is 1'bz whenever the synced ss is high and during reset, allowing multiple slaves to share one line.
  - Undefined: miso is driven 0 in those conditions.

Decomposition:
- Shared package spi_pkg holds:
  - The register address constants (ADDR_TX=0, ADDR_CTRL=2, ADDR_RX=4, ADDR_STATUS=8).
  - Status bit indices.
  - The FSM state encoding.
  - DATA_W.
- One sub-module, spi_sync_edge: SYNC_STAGES-deep synchronizer plus rise/fall pulse generator. Instantiated for sck and ss; mosi uses the synchronizer only.

Test Plan:
- Preload tx 0x5A; master sends 0xB9 at clk/8 → miso bits 0,1,0,1,1,0,1,0; status reads 0x0001; rx read returns 0x00B9; status then reads 0x0000.
- Two frames 0x11, 0x22 with no rx read in between → status 0x0005; rx read returns 0x0022; status then reads 0x0000.
- No tx preload; master sends 0x3C → miso returns 0xFF; rx returns 0x003C; tx_pending stays 0.
- ss deasserted after 3 sck rises, then full frame 0xA5 → no new_data after the abort; rx returns 0x00A5 after the full frame.
- rst pulled low mid-frame (after 4 bits) → d_out=0, miso=0, status 0x0000; the next full frame 0x81 is received correctly.
- Build with SPI_SLAVE_MISO_TRISTATE_EN → miso is z while ss=1 and driven during the frame; without the macro → miso is 0 while ss=1.
